rv32i_multicycle_ctrl: RTL

- Multi-cycle sequencer for the RV32I core. Replaces single-cycle control with an FSM that issues the existing datapath controls (regFileWe, aluControl, aluSrcMuxSel, dataWe, wdataSel) one phase at a time.
- Adds PC and instruction-register enables, plus a memory handshake (memReq/dataReady) with timeout.
- Sits between the instruction register and the register file, ALU and data-memory interface.

---
 rtl/rv32i_multicycle_ctrl_pkg.sv | 35 +++
 rtl/rv32i_multicycle_ctrl_if.sv | 28 ++
 rtl/rv32i_alu_decoder.sv | 30 +++
 rtl/rv32i_multicycle_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, ALU codes,
// FSM states and the opcode classifier.
package rv32i_multicycle_ctrl_pkg;

  localparam logic [6:0] OP_TYPE_R = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I = 7'b0010011;
  localparam logic [6:0] OP_TYPE_S = 7'b0100011;
  localparam logic [6:0] OP_TYPE_L = 7'b0000011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB} state_t;

  typedef enum logic [2:0] {OPC_R, OPC_I, OPC_S, OPC_L, OPC_BAD} op_class_t;

  function automatic op_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_TYPE_R: return OPC_R;
      OP_TYPE_I: return OPC_I;
      OP_TYPE_S: return OPC_S;
      OP_TYPE_L: return OPC_L;
      default:   return OPC_BAD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/handshake inputs and control strobes.
// master is the controller side, slave is the datapath/memory side.
interface rv32i_multicycle_ctrl_if;
  logic [31:0] instrCode;
  logic        dataReady;
  logic        pcEn;
  logic        irWe;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic        dataWe;
  logic        wdataSel;
  logic        memReq;
  logic        illegalInstr;
  logic        memErr;

  modport master (
    input  instrCode, dataReady,
    output pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel,
           dataWe, wdataSel, memReq, illegalInstr, memErr
  );

  modport slave (
    output instrCode, dataReady,
    input  pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel,
           dataWe, wdataSel, memReq, illegalInstr, memErr
  );
endinterface

// File: rtl/rv32i_alu_decoder.sv
// Combinational opcode/funct decoder: instruction class, ALU operation and
// operand-B select. Also used by the single-cycle core.
module rv32i_alu_decoder
  import rv32i_multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output op_class_t  op_class,
  output logic [3:0] alu_ctrl,
  output logic       alu_src
);

  always_comb begin
    op_class = classify(opcode);
    alu_ctrl = ALU_ADD;
    alu_src  = 1'b0;
    case (op_class)
      OPC_R: alu_ctrl = {funct7_5, funct3};
      OPC_I: begin
        alu_src = 1'b1;
        // instr[30] is an immediate bit for every I-op except the shift-right pair
        alu_ctrl = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
      end
      OPC_S, OPC_L: alu_src = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXE/MEM/WB FSM issuing datapath
// strobes one phase at a time, with a bounded wait for data memory.
module rv32i_multicycle_ctrl
  import rv32i_multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  rv32i_multicycle_ctrl_if.master bus
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               hold_reg;

  op_class_t          op_class;
  logic [3:0]         dec_alu_ctrl;
  logic               dec_alu_src;
  logic               is_store, is_load, is_alu_op;
  logic               timeout;
  logic               active;

  logic               pc_en, ir_we, rf_we, alu_src, data_we, wdata_sel;
  logic               mem_req, illegal, mem_err;
  logic [3:0]         alu_ctrl;
  logic               unused_instr_bits;

  rv32i_alu_decoder u_alu_decoder (
    .opcode   (bus.instrCode[6:0]),
    .funct3   (bus.instrCode[14:12]),
    .funct7_5 (bus.instrCode[30]),
    .op_class (op_class),
    .alu_ctrl (dec_alu_ctrl),
    .alu_src  (dec_alu_src)
  );

  assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};

  assign is_store  = (op_class == OPC_S);
  assign is_load   = (op_class == OPC_L);
  assign is_alu_op = (op_class == OPC_R) || (op_class == OPC_I);
  assign timeout   = (cnt_reg == CNT_W'(MEM_TIMEOUT));
  // Quiet for one cycle after reset releases, and never strobe while reset is held.
  assign active    = !reset && !hold_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
      hold_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!hold_reg) begin
      case (state_reg)
        FETCH:  state_next = DECODE;
        DECODE: state_next = (op_class == OPC_BAD) ? FETCH : EXE;
        EXE:    state_next = (is_store || is_load) ? MEM : FETCH;
        MEM: begin
          if (bus.dataReady) begin
            cnt_next   = '0;
            state_next = is_load ? WB : FETCH;
          end else if (timeout) begin
            cnt_next   = '0;
            state_next = FETCH;
          end else begin
            cnt_next   = cnt_reg + 1'b1;
          end
        end
        WB:      state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_en     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_src   = 1'b0;
    data_we   = 1'b0;
    wdata_sel = 1'b0;
    mem_req   = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    if (active) begin
      case (state_reg)
        FETCH: ir_we = 1'b1;
        DECODE: begin
          if (op_class == OPC_BAD) begin
            pc_en   = 1'b1;
            illegal = 1'b1;
          end
        end
        EXE: begin
          alu_ctrl = dec_alu_ctrl;
          alu_src  = dec_alu_src;
          if (is_alu_op) begin
            rf_we = 1'b1;
            pc_en = 1'b1;
          end
        end
        MEM: begin
          alu_ctrl = dec_alu_ctrl;
          alu_src  = dec_alu_src;
          mem_req  = 1'b1;
          data_we  = is_store;
          if (bus.dataReady) begin
            pc_en = is_store;
          end else if (timeout) begin
            mem_err = 1'b1;
            pc_en   = 1'b1;
          end
        end
        WB: begin
          alu_ctrl  = dec_alu_ctrl;
          alu_src   = dec_alu_src;
          rf_we     = 1'b1;
          wdata_sel = 1'b1;
          pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pcEn         = pc_en;
  assign bus.irWe         = ir_we;
  assign bus.regFileWe    = rf_we;
  assign bus.aluControl   = alu_ctrl;
  assign bus.aluSrcMuxSel = alu_src;
  assign bus.dataWe       = data_we;
  assign bus.wdataSel     = wdata_sel;
  assign bus.memReq       = mem_req;
  assign bus.illegalInstr = illegal;
  assign bus.memErr       = mem_err;

endmodule
